// File: rtl/multi_lane_skew_gen_pkg.sv
// Shared defaults and address helpers for the multi-lane skew channel model.
package multi_lane_skew_gen_pkg;

  localparam int unsigned NbCodedBlockDflt = 66;
  localparam int unsigned NLanesDflt       = 20;
  localparam int unsigned MaxSkewDflt      = 16;

  // Out-of-range skew requests saturate at the deepest usable tap.
  function automatic int unsigned clamp_skew(input int unsigned skew,
                                             input int unsigned depth);
    return (skew >= depth) ? depth - 1 : skew;
  endfunction

  // Circular-buffer read tap; depth need not be a power of two.
  function automatic int unsigned skew_rd_addr(input int unsigned wr_ptr,
                                               input int unsigned skew,
                                               input int unsigned depth);
    return (wr_ptr < skew) ? wr_ptr + depth - skew : wr_ptr - skew;
  endfunction

endpackage

// File: rtl/multi_lane_skew_gen_skew_lane_buffer.sv
// One lane of the skew generator: circular buffer of {tag, block}, write pointer,
// skew register, fill counter and registered output.
module multi_lane_skew_gen_skew_lane_buffer
  import multi_lane_skew_gen_pkg::*;
#(
  parameter int unsigned NbBlock = 66,
  parameter int unsigned MaxSkew = 16,
  parameter int unsigned NbSel   = $clog2(MaxSkew)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               valid_i,
  input  logic [NbBlock-1:0] data_i,
  input  logic               tag_i,
  input  logic               rf_update_i,
  input  logic [NbSel-1:0]   rf_skew_i,
  output logic [NbBlock-1:0] data_o,
  output logic               tag_o,
  output logic               valid_o,
  output logic               fill_done_o
);

  logic [NbBlock:0] mem_q [MaxSkew];
  logic [NbSel-1:0] wr_ptr_q, wr_ptr_d;
  logic [NbSel-1:0] skew_q, skew_d;
  logic [NbSel-1:0] fill_q, fill_d;
  logic [NbBlock:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             accept;
  logic             fill_done;
  logic [NbSel-1:0] rd_addr;
  logic [NbSel-1:0] skew_new;
  logic [NbBlock:0] wr_word;

  assign accept    = enable_i & valid_i & ~rf_update_i;
  assign fill_done = (fill_q >= skew_q);
  assign wr_word   = {tag_i, data_i};
  assign skew_new  = NbSel'(clamp_skew(32'(rf_skew_i), MaxSkew));
  assign rd_addr   = NbSel'(skew_rd_addr(32'(wr_ptr_q), 32'(skew_q), MaxSkew));

  // Next-state: update beats accept; output presents the block skew_q accepts back.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    skew_d   = skew_q;
    fill_d   = fill_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    if (rf_update_i) begin
      skew_d = skew_new;
      fill_d = '0;
    end else if (accept) begin
      wr_ptr_d = (wr_ptr_q == NbSel'(MaxSkew - 1)) ? '0 : wr_ptr_q + NbSel'(1);
      if (fill_q != NbSel'(MaxSkew - 1)) begin
        fill_d = fill_q + NbSel'(1);
      end
      if (fill_done) begin
        // Zero skew reads the block being written this cycle, not the stale slot.
        out_d   = (skew_q == '0) ? wr_word : mem_q[rd_addr];
        valid_d = 1'b1;
      end else begin
        out_d = '0;
      end
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      skew_q   <= '0;
      fill_q   <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      skew_q   <= skew_d;
      fill_q   <= fill_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  // Buffer storage; contents are not reset since fill tracking masks stale slots.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign data_o      = out_q[NbBlock-1:0];
  assign tag_o       = out_q[NbBlock];
  assign valid_o     = valid_q;
  assign fill_done_o = fill_done;

endmodule

// File: rtl/multi_lane_skew_gen.sv
// Multi-lane skew generator: independent programmable per-lane block delay for
// deskew stress in the loopback channel model. All lanes reprogram atomically.
module multi_lane_skew_gen
  import multi_lane_skew_gen_pkg::*;
#(
  parameter int unsigned NB_CODED_BLOCK = NbCodedBlockDflt,
  parameter int unsigned N_LANES        = NLanesDflt,
  parameter int unsigned MAX_SKEW       = MaxSkewDflt,
  parameter int unsigned NB_SKEW_SELECT = $clog2(MAX_SKEW)
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_enable,
  input  logic                               i_valid,
  input  logic [N_LANES*NB_CODED_BLOCK-1:0]  i_data,
  input  logic [N_LANES-1:0]                 i_aligner_tag,
  input  logic                               i_rf_update,
  input  logic [N_LANES*NB_SKEW_SELECT-1:0]  i_rf_skew,
  output logic [N_LANES*NB_CODED_BLOCK-1:0]  o_data,
  output logic [N_LANES-1:0]                 o_aligner_tag,
  output logic [N_LANES-1:0]                 o_valid,
  output logic                               o_busy
);

  logic [N_LANES-1:0] fill_done;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    multi_lane_skew_gen_skew_lane_buffer #(
      .NbBlock (NB_CODED_BLOCK),
      .MaxSkew (MAX_SKEW),
      .NbSel   (NB_SKEW_SELECT)
    ) u_lane (
      .clk_i       (i_clock),
      .rst_i       (i_reset),
      .enable_i    (i_enable),
      .valid_i     (i_valid),
      .data_i      (i_data[k*NB_CODED_BLOCK +: NB_CODED_BLOCK]),
      .tag_i       (i_aligner_tag[k]),
      .rf_update_i (i_rf_update),
      .rf_skew_i   (i_rf_skew[k*NB_SKEW_SELECT +: NB_SKEW_SELECT]),
      .data_o      (o_data[k*NB_CODED_BLOCK +: NB_CODED_BLOCK]),
      .tag_o       (o_aligner_tag[k]),
      .valid_o     (o_valid[k]),
      .fill_done_o (fill_done[k])
    );
  end

  assign o_busy = |(~fill_done);

endmodule

// File: tb/tb_multi_lane_skew_gen.sv
// Directed bench for multi_lane_skew_gen: a 20-lane/depth-16 instance driven through
// pass-through, staggered skew, wrap, idle gaps, updates, enable freeze and reset,
// plus a 2-lane/depth-20 instance for non-power-of-two wrap and skew clamping.
module tb_multi_lane_skew_gen;

  localparam int unsigned NB   = 66;
  localparam int unsigned NL   = 20;
  localparam int unsigned MS   = 16;
  localparam int unsigned NS   = 4;
  localparam int unsigned NL_B = 2;
  localparam int unsigned MS_B = 20;
  localparam int unsigned NS_B = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             en, vld, upd, busy;
  logic [NL*NB-1:0] din, dout;
  logic [NL-1:0]    tin, tout, vout;
  logic [NL*NS-1:0] skw;

  logic               en_b, vld_b, upd_b, busy_b;
  logic [NL_B*NB-1:0] din_b, dout_b;
  logic [NL_B-1:0]    tin_b, tout_b, vout_b;
  logic [NL_B*NS_B-1:0] skw_b;

  multi_lane_skew_gen #(
    .NB_CODED_BLOCK (NB),
    .N_LANES        (NL),
    .MAX_SKEW       (MS),
    .NB_SKEW_SELECT (NS)
  ) u_dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_valid       (vld),
    .i_data        (din),
    .i_aligner_tag (tin),
    .i_rf_update   (upd),
    .i_rf_skew     (skw),
    .o_data        (dout),
    .o_aligner_tag (tout),
    .o_valid       (vout),
    .o_busy        (busy)
  );

  multi_lane_skew_gen #(
    .NB_CODED_BLOCK (NB),
    .N_LANES        (NL_B),
    .MAX_SKEW       (MS_B),
    .NB_SKEW_SELECT (NS_B)
  ) u_dut_b (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en_b),
    .i_valid       (vld_b),
    .i_data        (din_b),
    .i_aligner_tag (tin_b),
    .i_rf_update   (upd_b),
    .i_rf_skew     (skw_b),
    .o_data        (dout_b),
    .o_aligner_tag (tout_b),
    .o_valid       (vout_b),
    .o_busy        (busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Block payload identifies lane and sequence number; tags mark every 5th block.
  function automatic logic [NB-1:0] mk(input int k, input int val);
    return {2'b01, 32'(k), 32'(val)};
  endfunction

  function automatic logic tg(input int k, input int val);
    return ((val + k) % 5) == 0;
  endfunction

  // Reference state for the wide instance.
  int          sk   [NL];
  int          pend [NL];
  logic [NB-1:0] ed [NL];
  logic [NL-1:0] et, ev;
  logic          eb;
  int            j, v;

  task automatic reset_model();
    for (int k = 0; k < NL; k++) begin
      sk[k]   = 0;
      pend[k] = 0;
      ed[k]   = '0;
    end
    et  = '0;
    ev  = '0;
    j   = 0;
    v   = 1;
    skw = '0;
  endtask

  task automatic set_pend(input int k, input int val);
    pend[k] = val;
    skw[k*NS +: NS] = NS'(val);
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < NL; k++) begin
      check_eq($sformatf("%s data[%0d]", tag, k), 128'(dout[k*NB +: NB]), 128'(ed[k]));
    end
    check_eq({tag, " tag"}, 128'(tout), 128'(et));
    check_eq({tag, " valid"}, 128'(vout), 128'(ev));
    check_eq({tag, " busy"}, 128'(busy), 128'(eb));
  endtask

  // One clock of the wide instance; the dropped update-cycle block carries 0xDEAD.
  task automatic step_a(input bit e, input bit va, input bit u, input string tag);
    en  = e;
    vld = va;
    upd = u;
    for (int k = 0; k < NL; k++) begin
      din[k*NB +: NB] = u ? mk(k, 32'hDEAD) : mk(k, v);
      tin[k]          = u ? 1'b1 : tg(k, v);
    end
    @(posedge clk);
    #1;
    ev = '0;
    if (u) begin
      for (int k = 0; k < NL; k++) sk[k] = pend[k];
      j = 0;
    end else if (e && va) begin
      for (int k = 0; k < NL; k++) begin
        if (j >= sk[k]) begin
          ev[k] = 1'b1;
          ed[k] = mk(k, v - sk[k]);
          et[k] = tg(k, v - sk[k]);
        end else begin
          ed[k] = '0;
          et[k] = 1'b0;
        end
      end
      v++;
      j++;
    end
    eb = 1'b0;
    for (int k = 0; k < NL; k++) if (j < sk[k]) eb = 1'b1;
    check_outputs(tag);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    vld   = 1'b0;
    upd   = 1'b0;
    din   = '0;
    tin   = '0;
    en_b  = 1'b0;
    vld_b = 1'b0;
    upd_b = 1'b0;
    din_b = '0;
    tin_b = '0;
    skw_b = '0;
    eb    = 1'b0;
    reset_model();
    #12;
    check_eq("reset valid", 128'(vout), 128'(0));
    check_eq("reset busy", 128'(busy), 128'(0));
    check_eq("reset tag", 128'(tout), 128'(0));
    check_eq("reset data0", 128'(dout[NB-1:0]), 128'(0));
    check_eq("reset b valid", 128'(vout_b), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero skew: one-cycle pass-through on every lane.
    for (int i = 0; i < 6; i++) step_a(1, 1, 0, "t1");
    check_eq("t1 lane3 hand", 128'(dout[3*NB +: NB]), 128'({2'b01, 32'd3, 32'd6}));

    // Staggered skew k%16; busy clears on the 15th accept.
    for (int k = 0; k < NL; k++) set_pend(k, k % 16);
    step_a(1, 1, 1, "t2 upd");
    for (int i = 0; i < 20; i++) begin
      step_a(1, 1, 0, "t2");
      if (i == 13) check_eq("t2 busy after 14", 128'(busy), 128'(1));
      if (i == 14) check_eq("t2 busy after 15", 128'(busy), 128'(0));
    end

    // Maximum skew on one lane across several pointer wraps.
    for (int k = 0; k < NL; k++) set_pend(k, (k == 5) ? MS - 1 : 0);
    step_a(1, 1, 1, "t3 upd");
    for (int i = 0; i < 3 * MS; i++) step_a(1, 1, 0, "t3");

    // Alternating valid: skew counts valid blocks, outputs hold while idle.
    for (int k = 0; k < NL; k++) set_pend(k, (3 * k) % 16);
    step_a(1, 1, 1, "t4 upd");
    for (int i = 0; i < 40; i++) step_a(1, (i % 2) == 0, 0, "t4");

    // Update with valid (dropped), then a second update while still busy.
    for (int k = 0; k < NL; k++) set_pend(k, 8);
    step_a(1, 1, 1, "t5 upd1");
    for (int i = 0; i < 3; i++) step_a(1, 1, 0, "t5a");
    check_eq("t5 busy mid", 128'(busy), 128'(1));
    for (int k = 0; k < NL; k++) set_pend(k, 15 - (k % 16));
    step_a(1, 1, 1, "t5 upd2");
    for (int i = 0; i < 18; i++) step_a(1, 1, 0, "t5b");

    // Enable low freezes state; an update is still taken while frozen.
    for (int i = 0; i < 3; i++) step_a(0, 1, 0, "en0");
    for (int k = 0; k < NL; k++) set_pend(k, 2);
    step_a(0, 1, 1, "en0 upd");
    step_a(0, 1, 0, "en0 hold");
    for (int i = 0; i < 4; i++) step_a(1, 1, 0, "en1");

    // Asynchronous reset mid-stream with skew 7 everywhere.
    for (int k = 0; k < NL; k++) set_pend(k, 7);
    step_a(1, 1, 1, "t6 upd");
    for (int i = 0; i < 10; i++) step_a(1, 1, 0, "t6");
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6 rst valid", 128'(vout), 128'(0));
    check_eq("t6 rst tag", 128'(tout), 128'(0));
    check_eq("t6 rst busy", 128'(busy), 128'(0));
    check_eq("t6 rst data9", 128'(dout[9*NB +: NB]), 128'(0));
    reset_model();
    eb = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step_a(1, 1, 0, "t6 post");

    // Depth-20 instance: lane0 requests 27 (clamps to 19), lane1 skew 7.
    en_b  = 1'b1;
    vld_b = 1'b1;
    upd_b = 1'b1;
    skw_b = {5'd7, 5'd27};
    din_b = {mk(1, 32'hDEAD), mk(0, 32'hDEAD)};
    tin_b = 2'b11;
    @(posedge clk);
    #1;
    check_eq("b upd valid", 128'(vout_b), 128'(0));
    check_eq("b upd busy", 128'(busy_b), 128'(1));
    upd_b = 1'b0;
    for (int n = 0; n < 3 * MS_B; n++) begin
      logic [NL_B-1:0] exp_v, exp_t;
      for (int k = 0; k < NL_B; k++) begin
        din_b[k*NB +: NB] = mk(k, n + 1);
        tin_b[k]          = tg(k, n + 1);
      end
      @(posedge clk);
      #1;
      exp_v = '0;
      exp_t = '0;
      for (int k = 0; k < NL_B; k++) begin
        int s;
        s = (k == 0) ? MS_B - 1 : 7;
        if (n >= s) begin
          exp_v[k] = 1'b1;
          exp_t[k] = tg(k, n + 1 - s);
          check_eq($sformatf("b data[%0d] n=%0d", k, n), 128'(dout_b[k*NB +: NB]),
                   128'(mk(k, n + 1 - s)));
        end else begin
          check_eq($sformatf("b data[%0d] n=%0d", k, n), 128'(dout_b[k*NB +: NB]), 128'(0));
        end
      end
      check_eq($sformatf("b valid n=%0d", n), 128'(vout_b), 128'(exp_v));
      check_eq($sformatf("b tag n=%0d", n), 128'(tout_b), 128'(exp_t));
      check_eq($sformatf("b busy n=%0d", n), 128'(busy_b), 128'((n + 1) < (MS_B - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
